// File: rtl/serial_number_receiver.sv
//==============================================================================
// Module      : serial_number_receiver
// Description : Bit-serial frame receiver (start, DATA_W LSB-first data bits,
//               optional even parity, stop) with valid/ready word output and
//               sticky frame/overrun/parity error flags.
//               Optional parity is enabled by defining SERIN_PARITY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_number_receiver #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serin,
    input  logic              ready,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic              par_err
);

    localparam int                 c_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SHIFT  = 3'd1;
    localparam logic [2:0] c_PARITY = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
    localparam logic [2:0] c_RESYNC = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [DATA_W-1:0]  r_sh;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;
    logic               w_load;
    logic               w_set_fe;
    logic               w_set_pe;
    logic               w_par_fail;

`ifdef SERIN_PARITY_EN
    logic r_par_bad;
    logic r_par_err;

    assign w_par_fail = r_par_bad;
`else
    assign w_par_fail = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_set_fe = 1'b0;
        w_set_pe = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!serin) w_next = c_SHIFT;
            end
            c_SHIFT: begin
                if (r_cnt == c_LAST) begin
`ifdef SERIN_PARITY_EN
                    w_next = c_PARITY;
`else
                    w_next = c_STOP;
`endif
                end
            end
            c_PARITY: begin
                w_next = c_STOP;
            end
            c_STOP: begin
                // A low stop bit is a framing error regardless of parity
                if (!serin) begin
                    w_set_fe = 1'b1;
                    w_next   = c_RESYNC;
                end else if (w_par_fail) begin
                    w_set_pe = 1'b1;
                    w_next   = c_IDLE;
                end else begin
                    w_load   = 1'b1;
                    w_next   = c_IDLE;
                end
            end
            c_RESYNC: begin
                if (serin) w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_IDLE && !serin) begin
                r_cnt <= '0;
            end else if (r_state == c_SHIFT) begin
                r_sh  <= {serin, r_sh[DATA_W-1:1]};
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Loads win over consumption, so a word arriving as the old one is taken keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_sh;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            if (w_load && r_valid && !ready) r_overrun <= 1'b1;
            else if (clr_err)                r_overrun <= 1'b0;

            if (w_set_fe)     r_frame_err <= 1'b1;
            else if (clr_err) r_frame_err <= 1'b0;
        end
    end

`ifdef SERIN_PARITY_EN
    // Even parity: the parity bit must equal the xor of the data bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            if (r_state == c_PARITY) r_par_bad <= (^r_sh) != serin;

            if (w_set_pe)     r_par_err <= 1'b1;
            else if (clr_err) r_par_err <= 1'b0;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = w_set_pe & 1'b0;
`endif

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = (r_state != c_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_serial_number_receiver.sv
// Scoreboard bench for serial_number_receiver: stimulus pushes expected words,
// a monitor pops and compares on every valid&&ready handshake.
`timescale 1ns/1ps
`default_nettype none

module tb_serial_number_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serin;
    logic       ready;
    logic       clr_err;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       par_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

`ifdef SERIN_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    serial_number_receiver #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .serin     (serin),
        .ready     (ready),
        .clr_err   (clr_err),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Leaves the task just after driving the stop bit (sampled at the next posedge)
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(negedge clk) serin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) serin = d[i];
        end
`ifdef SERIN_PARITY_EN
        @(negedge clk) serin = (^d) ^ par_flip;
`endif
        @(negedge clk) serin = stop_bit;
    endtask

    // Monitor: samples between negedge (input changes) and the next posedge
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%0h expected no word at %0t", data, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got 0x%0h expected 0x%0h at %0t", data, e, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        serin   = 1'b1;
        ready   = 1'b1;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_busy",  busy,  0);
        check("rst_data",  data,  0);
        rst_n = 1'b1;

        // 1: idle line
        repeat (20) @(negedge clk);
        check("idle_valid", valid,     0);
        check("idle_busy",  busy,      0);
        check("idle_fe",    frame_err, 0);
        check("idle_ovr",   overrun,   0);
        check("idle_pe",    par_err,   0);

        // 2: single good frame, latency and one-cycle valid pulse
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check("t2_valid_before_stop", valid, 0);
        check("t2_busy_in_frame",     busy,  1);
        @(negedge clk) serin = 1'b1;
        check("t2_valid_after_stop",  valid, 1);
        check("t2_data",              data,  8'hA5);
        @(negedge clk);
        check("t2_valid_pulse",       valid, 0);
        check("t2_busy_idle",         busy,  0);

        // 3: back-to-back frames with ready low -> overrun
        ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        @(negedge clk) serin = 1'b1;
        check("t3_valid",   valid,   1);
        check("t3_data",    data,    8'hC3);
        check("t3_overrun", overrun, 1);
        clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        check("t3_ovr_clr",   overrun, 0);
        check("t3_data_hold", data,    8'hC3);
        check("t3_valid_hold", valid,  1);
        exp_q.push_back(8'hC3);
        ready = 1'b1;
        @(negedge clk);
        check("t3_consumed", valid, 0);

        // 4: bad stop bit, stuck-low line, recovery
        send_frame(8'h5A, 1'b0);
        @(negedge clk) serin = 1'b0;
        check("t4_fe",    frame_err, 1);
        check("t4_valid", valid,     0);
        check("t4_busy",  busy,      1);
        repeat (3) @(negedge clk);
        check("t4_busy_stuck", busy, 1);
        serin = 1'b1;
        @(negedge clk);
        check("t4_busy_released", busy, 0);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        @(negedge clk) serin = 1'b1;
        check("t4_data", data, 8'h01);
        check("t4_fe_sticky", frame_err, 1);

        // 5: async reset during 4th data bit of 8'hFF
        @(negedge clk) serin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) serin = 1'b1;
        end
        #1 rst_n = 1'b0;
        #1;
        check("t5_data",  data,      0);
        check("t5_valid", valid,     0);
        check("t5_busy",  busy,      0);
        check("t5_fe",    frame_err, 0);
        check("t5_ovr",   overrun,   0);
        check("t5_pe",    par_err,   0);
        @(negedge clk) serin = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("t5_idle_after", busy, 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        @(negedge clk) serin = 1'b1;
        check("t5_data_after", data, 8'h12);

`ifdef SERIN_PARITY_EN
        // 6: parity good then bad
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        @(negedge clk) serin = 1'b1;
        check("t6_good_data", data,    8'h07);
        check("t6_good_pe",   par_err, 0);
        @(negedge clk);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        @(negedge clk) serin = 1'b1;
        par_flip = 1'b0;
        check("t6_bad_pe",    par_err, 1);
        check("t6_bad_valid", valid,   0);
        check("t6_bad_busy",  busy,    0);
`endif

        repeat (4) @(negedge clk);
        #3;
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
